ps2_scancode_rx: RTL and testbench

PS/2 keyboard receiver that turns the raw `ps2_clk`/`ps2_data` lines into validated scan codes for the PWM duty selector. It runs in the `clkdiv4` domain and decodes the host-side 11-bit device-to-host frame: start, 8 data bits LSB first, odd parity, stop. It tracks the `E0`/`F0` prefixes and presents the last make code as a held level on `scancode`, plus one-cycle event strobes.

---
 rtl/ps2_scancode_rx_pkg.sv | 27 ++
 rtl/ps2_filter.sv | 59 +++++
 rtl/ps2_scancode_rx.sv | 152 +++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM states, prefix bytes,
// the PWM selector's command keys and the frame parity check.
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int unsigned PS2_LINES = 2;   // index 0: clock, index 1: data

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Make codes the PWM duty selector reacts to
    localparam logic [7:0] PS2_KEY_F = 8'h2B;
    localparam logic [7:0] PS2_KEY_Q = 8'h15;
    localparam logic [7:0] PS2_KEY_H = 8'h33;
    localparam logic [7:0] PS2_KEY_X = 8'h22;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 line conditioning: 2-flop synchronizer and consecutive-sample glitch filter
// on both lines, plus a registered falling-edge tick on the filtered clock.
module ps2_filter
    import ps2_scancode_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PS2_LINES-1:0] line_i,
    output logic                 data_o,
    output logic                 fall_o
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [PS2_LINES-1:0]         sync1_q, sync2_q;
    logic [PS2_LINES-1:0]         filt_q, filt_d;
    logic [PS2_LINES-1:0][CW-1:0] cnt_q, cnt_d;
    logic                         clk_dly_q;
    logic                         fall_q;

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int unsigned i = 0; i < PS2_LINES; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            filt_q    <= '1;
            cnt_q     <= '0;
            clk_dly_q <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= line_i;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
            clk_dly_q <= filt_q[0];
            fall_q    <= clk_dly_q & ~filt_q[0];
        end
    end

    assign data_o = filt_q[1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames device-to-host bytes, tracks E0/F0 prefixes and
// presents make/break codes as held levels with one-cycle event strobes.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2500
) (
    input  logic       clkdiv4,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] break_code,
    output logic       extended,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          fall;
    logic          data;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          ext_pend_q;
    logic          brk_pend_q;
    logic [7:0]    scancode_q;
    logic [7:0]    break_code_q;
    logic          extended_q;
    logic          make_q;
    logic          brk_q;
    logic          err_q;

    ps2_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk_i  (clkdiv4),
        .rst_i  (reset),
        .line_i ({ps2_data, ps2_clk}),
        .data_o (data),
        .fall_o (fall)
    );

    always_ff @(posedge clkdiv4 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            scancode_q   <= '0;
            break_code_q <= '0;
            extended_q   <= 1'b0;
            make_q       <= 1'b0;
            brk_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            make_q <= 1'b0;
            brk_q  <= 1'b0;
            err_q  <= 1'b0;

            // The cycle that consumes fall counts as the first elapsed cycle,
            // so the error strobe lands TIMEOUT_CYCLES after the fall tick.
            if (state_q == ST_IDLE) begin
                tmo_q <= '0;
            end else if (fall) begin
                tmo_q <= TW'(1);
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (fall && !data) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shift_q   <= {data, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        parity_q <= data;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                        if (data && odd_parity_ok(shift_q, parity_q)) begin
                            if (shift_q == PS2_EXT) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == PS2_BRK) begin
                                brk_pend_q <= 1'b1;
                            end else if (brk_pend_q) begin
                                break_code_q <= shift_q;
                                extended_q   <= ext_pend_q;
                                brk_q        <= 1'b1;
                                ext_pend_q   <= 1'b0;
                                brk_pend_q   <= 1'b0;
                            end else begin
                                scancode_q <= shift_q;
                                extended_q <= ext_pend_q;
                                make_q     <= 1'b1;
                                ext_pend_q <= 1'b0;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A fall in the same cycle restarts the count, so this never overlaps stop handling
            if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_q    <= ST_IDLE;
                shift_q    <= '0;
                err_q      <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end
        end
    end

    assign scancode    = scancode_q;
    assign break_code  = break_code_q;
    assign extended    = extended_q;
    assign make_pulse  = make_q;
    assign break_pulse = brk_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: a byte table plus timeout / glitch / reset sequences,
// with every strobe checked against a cycle-stamped queue of expected events.
module tb_ps2_scancode_rx;
    import ps2_scancode_rx_pkg::*;

    localparam int unsigned F = 4;    // filter depth used for this bench
    localparam int unsigned T = 100;  // timeout, > falling-edge spacing of 2*H
    localparam int unsigned H = 20;   // PS/2 clock half period in system cycles
    localparam int unsigned NV = 19;

    typedef enum logic [1:0] {K_NONE, K_MAKE, K_BRK, K_ERR} kind_e;

    typedef struct {
        kind_e      kind;
        logic [7:0] code;
        logic       ext;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        kind_e      kind;
        logic [7:0] sc;
        logic [7:0] bc;
        logic       ext;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       make_pulse;
    logic       break_pulse;
    logic [7:0] break_code;
    logic       extended;
    logic       frame_err;
    logic       busy;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_fall = 0;
    exp_t sb[$];
    vec_t tbl[NV];

    ps2_scancode_rx #(
        .FILTER_LEN(F),
        .TIMEOUT_CYCLES(T)
    ) u_dut (
        .clkdiv4    (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scancode   (scancode),
        .make_pulse (make_pulse),
        .break_pulse(break_pulse),
        .break_code (break_code),
        .extended   (extended),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // bits[0] is sent first; the expectation is queued just before the last falling edge
    task automatic send_frame(input logic [10:0] bits, input int n, input exp_t e, input bit push);
        exp_t q;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            step(H / 2);
            if (push && i == n - 1) begin
                q     = e;
                q.cyc = cyc + int'(F) + 4;
                sb.push_back(q);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            step(H);
            ps2_clk = 1'b1;
            step(H / 2);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = bad_par ? ^d : ~^d;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Strobe monitor: every strobe must match the head of the queue, including its cycle
    always @(negedge clk) begin
        exp_t  e;
        kind_e got;
        bit    ok;
        if (!reset && (make_pulse || break_pulse || frame_err)) begin
            n_vec++;
            if ((32'(make_pulse) + 32'(break_pulse) + 32'(frame_err)) != 1) got = K_NONE;
            else if (make_pulse)  got = K_MAKE;
            else if (break_pulse) got = K_BRK;
            else                  got = K_ERR;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: kind %0d at cycle %0d, required no strobe", got, cyc);
            end else begin
                e  = sb.pop_front();
                ok = (got == e.kind) && (cyc == e.cyc);
                case (e.kind)
                    K_MAKE:  ok = ok && (scancode == e.code) && (extended == e.ext);
                    K_BRK:   ok = ok && (break_code == e.code) && (extended == e.ext);
                    K_ERR:   ok = ok && !busy;
                    default: ok = 1'b0;
                endcase
                if (!ok) begin
                    n_err++;
                    $display("FAIL event: got kind %0d cyc %0d sc %0h bc %0h ext %0b busy %0b, required kind %0d cyc %0d code %0h ext %0b",
                             got, cyc, scancode, break_code, extended, busy, e.kind, e.cyc, e.code, e.ext);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        tbl[0]  = '{PS2_KEY_F, 1'b0, 1'b0, K_MAKE, 8'h2B, 8'h00, 1'b0};
        tbl[1]  = '{PS2_BRK,   1'b0, 1'b0, K_NONE, 8'h2B, 8'h00, 1'b0};
        tbl[2]  = '{PS2_KEY_F, 1'b0, 1'b0, K_BRK,  8'h2B, 8'h2B, 1'b0};
        tbl[3]  = '{PS2_EXT,   1'b0, 1'b0, K_NONE, 8'h2B, 8'h2B, 1'b0};
        tbl[4]  = '{8'h75,     1'b0, 1'b0, K_MAKE, 8'h75, 8'h2B, 1'b1};
        tbl[5]  = '{PS2_KEY_Q, 1'b0, 1'b0, K_MAKE, 8'h15, 8'h2B, 1'b0};
        tbl[6]  = '{PS2_KEY_Q, 1'b1, 1'b0, K_ERR,  8'h15, 8'h2B, 1'b0};
        tbl[7]  = '{PS2_KEY_H, 1'b0, 1'b0, K_MAKE, 8'h33, 8'h2B, 1'b0};
        tbl[8]  = '{PS2_KEY_H, 1'b0, 1'b0, K_MAKE, 8'h33, 8'h2B, 1'b0};
        tbl[9]  = '{PS2_EXT,   1'b0, 1'b0, K_NONE, 8'h33, 8'h2B, 1'b0};
        tbl[10] = '{PS2_BRK,   1'b0, 1'b0, K_NONE, 8'h33, 8'h2B, 1'b0};
        tbl[11] = '{8'h75,     1'b0, 1'b0, K_BRK,  8'h33, 8'h75, 1'b1};
        tbl[12] = '{PS2_EXT,   1'b0, 1'b0, K_NONE, 8'h33, 8'h75, 1'b1};
        tbl[13] = '{PS2_KEY_X, 1'b1, 1'b0, K_ERR,  8'h33, 8'h75, 1'b1};
        tbl[14] = '{PS2_KEY_X, 1'b0, 1'b0, K_MAKE, 8'h22, 8'h75, 1'b0};
        tbl[15] = '{PS2_BRK,   1'b1, 1'b0, K_ERR,  8'h22, 8'h75, 1'b0};
        tbl[16] = '{PS2_KEY_F, 1'b0, 1'b0, K_MAKE, 8'h2B, 8'h75, 1'b0};
        tbl[17] = '{8'h44,     1'b0, 1'b1, K_ERR,  8'h2B, 8'h75, 1'b0};
        tbl[18] = '{PS2_KEY_Q, 1'b0, 1'b0, K_MAKE, 8'h15, 8'h75, 1'b0};

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        step(3);
        chk("rst_scancode",   32'(scancode),    32'h00);
        chk("rst_break_code", 32'(break_code),  32'h00);
        chk("rst_extended",   32'(extended),    32'h0);
        chk("rst_busy",       32'(busy),        32'h0);
        chk("rst_strobes",    32'({make_pulse, break_pulse, frame_err}), 32'h0);
        reset = 1'b0;
        step(5);

        for (int unsigned v = 0; v < NV; v++) begin
            e.kind = tbl[v].kind;
            e.code = (tbl[v].kind == K_BRK) ? tbl[v].bc : tbl[v].sc;
            e.ext  = tbl[v].ext;
            e.cyc  = 0;
            send_frame(mk_frame(tbl[v].data, tbl[v].bad_par, tbl[v].bad_stop), 11, e, tbl[v].kind != K_NONE);
            step(10);
            chk($sformatf("v%0d_scancode", v),   32'(scancode),   32'(tbl[v].sc));
            chk($sformatf("v%0d_break_code", v), 32'(break_code), 32'(tbl[v].bc));
            chk($sformatf("v%0d_extended", v),   32'(extended),   32'(tbl[v].ext));
            chk($sformatf("v%0d_drained", v),    32'(sb.size()),  32'd0);
        end

        // Five bits then silence: error exactly T cycles after the last fall tick
        e = '{K_NONE, 8'h00, 1'b0, 0};
        send_frame(mk_frame(8'h5A, 1'b0, 1'b0), 5, e, 1'b0);
        chk("tmo_busy_mid", 32'(busy), 32'h1);
        e = '{K_ERR, 8'h00, 1'b0, last_fall + int'(F) + 3 + int'(T)};
        sb.push_back(e);
        step(T + F + 20);
        chk("tmo_drained", 32'(sb.size()), 32'd0);
        chk("tmo_busy",    32'(busy),      32'h0);
        e = '{K_MAKE, 8'h22, 1'b0, 0};
        send_frame(mk_frame(PS2_KEY_X, 1'b0, 1'b0), 11, e, 1'b1);
        step(10);
        chk("tmo_next_scancode", 32'(scancode), 32'h22);
        chk("tmo_next_drained",  32'(sb.size()), 32'd0);

        // Short low glitch on the clock while idle
        ps2_clk = 1'b0;
        step(3);
        ps2_clk = 1'b1;
        step(30);
        chk("glitch_busy", 32'(busy), 32'h0);
        e = '{K_MAKE, 8'h2B, 1'b0, 0};
        send_frame(mk_frame(PS2_KEY_F, 1'b0, 1'b0), 11, e, 1'b1);
        step(10);
        chk("glitch_next_scancode", 32'(scancode), 32'h2B);
        chk("glitch_next_drained",  32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a frame
        e = '{K_NONE, 8'h00, 1'b0, 0};
        send_frame(mk_frame(8'h66, 1'b0, 1'b0), 4, e, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_scancode",   32'(scancode),   32'h00);
        chk("mid_rst_break_code", 32'(break_code), 32'h00);
        chk("mid_rst_busy",       32'(busy),       32'h0);
        step(2);
        reset = 1'b0;
        step(10);
        e = '{K_MAKE, 8'h2B, 1'b0, 0};
        send_frame(mk_frame(PS2_KEY_F, 1'b0, 1'b0), 11, e, 1'b1);
        step(10);
        chk("rst_next_scancode",   32'(scancode),   32'h2B);
        chk("rst_next_break_code", 32'(break_code), 32'h00);
        chk("rst_next_drained",    32'(sb.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
